grid_mem_arbiter: RTL and testbench

- Shares one single-port grid RAM (ADDR_W address, DATA_W cell status) between two requesters.
- Requesters: the game FSM (read/write) and the VGA grid renderer (read-only).
- Video gets priority, with an anti-starvation guarantee for the game FSM.
- Also contains a clear sequencer that writes GRID_STATUS_EMPTY to every cell before a new game.

---
 rtl/grid_pkg.sv | 23 ++
 rtl/rd_tag_pipe.sv | 38 +++
 rtl/grid_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared cell codes, default widths and enums
// for the battleship grid memory subsystem.
package grid_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 2;

    localparam logic [1:0] GRID_STATUS_EMPTY  = 2'b00;
    localparam logic [1:0] GRID_STATUS_MYSHIP = 2'b01;
    localparam logic [1:0] GRID_STATUS_MISS   = 2'b10;
    localparam logic [1:0] GRID_STATUS_HIT    = 2'b11;

    typedef enum logic {
        OWN_GAME = 1'b0,
        OWN_VID  = 1'b1
    } owner_e;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register of {valid, owner}
// tags that follows a read through a fixed-latency RAM.
module rd_tag_pipe
    import grid_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  owner_e i_owner,
    output logic   o_valid,
    output owner_e o_owner
);

    logic [DEPTH-1:0] r_valid;
    owner_e           r_owner [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_owner[i] <= OWN_GAME;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_owner[0] <= i_owner;
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_owner[i] <= r_owner[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_owner = r_owner[DEPTH-1];

endmodule

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: shares the single-port grid RAM between the game FSM
// and the VGA renderer, and sweeps the grid empty before a new game.
module grid_mem_arbiter
    import grid_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GRID_CELLS = 100,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_req,
    input  logic              game_w_nr,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_w_nr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(GRID_CELLS - 1);
    localparam logic [DATA_W-1:0] EMPTY      = DATA_W'(GRID_STATUS_EMPTY);

    if (GRID_CELLS < 1 || GRID_CELLS > (2 ** ADDR_W)) begin : g_chk_cells
        $error("GRID_CELLS does not fit the ADDR_W address space");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
        $error("RD_LATENCY must be 1..4");
    end
    if (MAX_WAIT < 1) begin : g_chk_wait
        $error("MAX_WAIT must be at least 1");
    end

    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [SW-1:0]     r_starve;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_w_nr;
    logic              r_clr_done;
    logic              r_tag_v;
    owner_e            r_tag_own;

    logic              w_run;
    logic              w_game_win;
    logic              w_game_gnt;
    logic              w_vid_gnt;
    logic              w_pipe_v;
    owner_e            w_pipe_own;

    // A pending clear request steals the cycle from both requesters.
    always_comb begin
        w_run      = (r_state == RUN);
        w_game_win = game_req && (!vid_req || (r_starve == STARVE_MAX));
        w_game_gnt = w_run && !clr_req && w_game_win;
        w_vid_gnt  = w_run && !clr_req && vid_req && !w_game_win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_w_nr  <= 1'b0;
            r_clr_done  <= 1'b0;
            r_tag_v     <= 1'b0;
            r_tag_own   <= OWN_GAME;
        end else begin
            r_clr_done <= 1'b0;
            r_tag_v    <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (game_req && !w_game_gnt) begin
                        if (r_starve != STARVE_MAX) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else begin
                        r_starve <= '0;
                    end
                    if (clr_req) begin
                        r_state     <= CLEAR;
                        r_cnt       <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= EMPTY;
                        r_mem_w_nr  <= 1'b1;
                    end else if (w_game_gnt) begin
                        r_mem_addr  <= game_addr;
                        r_mem_wdata <= game_wdata;
                        r_mem_w_nr  <= game_w_nr;
                        r_tag_v     <= !game_w_nr;
                        r_tag_own   <= OWN_GAME;
                    end else if (w_vid_gnt) begin
                        r_mem_addr <= vid_addr;
                        r_mem_w_nr <= 1'b0;
                        r_tag_v    <= 1'b1;
                        r_tag_own  <= OWN_VID;
                    end else begin
                        r_mem_w_nr <= 1'b0;
                    end
                end
                CLEAR: begin
                    // mem_addr already shows r_cnt; advance or finish.
                    if (r_cnt == LAST_CELL) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        r_mem_w_nr <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_mem_addr <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_tag_v),
        .i_owner (r_tag_own),
        .o_valid (w_pipe_v),
        .o_owner (w_pipe_own)
    );

    assign game_gnt    = w_game_gnt;
    assign vid_gnt     = w_vid_gnt;
    assign game_rvalid = w_pipe_v && (w_pipe_own == OWN_GAME);
    assign vid_rvalid  = w_pipe_v && (w_pipe_own == OWN_VID);
    assign game_rdata  = mem_rdata;
    assign vid_rdata   = mem_rdata;
    assign clr_busy    = (r_state == CLEAR);
    assign clr_done    = r_clr_done;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_w_nr    = r_mem_w_nr;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter: two arbiters (read latency 1 and 2) on shared
// stimulus, each with its own RAM, checked against a behavioural model.
`timescale 1ns/1ps
module tb_grid_mem_arbiter;
    import grid_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 2;
    localparam int CELLS = 100;
    localparam int MW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          game_req, game_w_nr, vid_req, clr_req;
    logic [AW-1:0] game_addr, vid_addr;
    logic [DW-1:0] game_wdata;

    logic          g1_gnt, g1_rv, v1_gnt, v1_rv, c1_busy, c1_done, m1_w;
    logic [DW-1:0] g1_rd, v1_rd, m1_wd, m1_rd;
    logic [AW-1:0] m1_a;
    logic          g2_gnt, g2_rv, v2_gnt, v2_rv, c2_busy, c2_done, m2_w;
    logic [DW-1:0] g2_rd, v2_rd, m2_wd, m2_rd;
    logic [AW-1:0] m2_a;

    grid_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .GRID_CELLS(CELLS),
        .RD_LATENCY(1), .MAX_WAIT(MW)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .game_req(game_req), .game_w_nr(game_w_nr),
        .game_addr(game_addr), .game_wdata(game_wdata),
        .game_gnt(g1_gnt), .game_rvalid(g1_rv), .game_rdata(g1_rd),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(v1_gnt), .vid_rvalid(v1_rv), .vid_rdata(v1_rd),
        .clr_req(clr_req), .clr_busy(c1_busy), .clr_done(c1_done),
        .mem_addr(m1_a), .mem_wdata(m1_wd), .mem_w_nr(m1_w),
        .mem_rdata(m1_rd)
    );

    grid_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .GRID_CELLS(CELLS),
        .RD_LATENCY(2), .MAX_WAIT(MW)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .game_req(game_req), .game_w_nr(game_w_nr),
        .game_addr(game_addr), .game_wdata(game_wdata),
        .game_gnt(g2_gnt), .game_rvalid(g2_rv), .game_rdata(g2_rd),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(v2_gnt), .vid_rvalid(v2_rv), .vid_rdata(v2_rd),
        .clr_req(clr_req), .clr_busy(c2_busy), .clr_done(c2_done),
        .mem_addr(m2_a), .mem_wdata(m2_wd), .mem_w_nr(m2_w),
        .mem_rdata(m2_rd)
    );

    // RAM models: latency 1 for dut1, latency 2 for dut2
    logic [DW-1:0] seed [256];
    logic [DW-1:0] ram1 [256];
    logic [DW-1:0] ram2 [256];
    logic [DW-1:0] p1, p2a, p2b;
    logic          seed_en;

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 256; i++) begin
                ram1[i] <= seed[i];
                ram2[i] <= seed[i];
            end
        end else begin
            if (m1_w) ram1[m1_a] <= m1_wd;
            if (m2_w) ram2[m2_a] <= m2_wd;
        end
        p1  <= ram1[m1_a];
        p2a <= ram2[m2_a];
        p2b <= p2a;
    end
    assign m1_rd = p1;
    assign m2_rd = p2b;

    // behavioural model state
    logic [DW-1:0] shadow [256];
    bit            m_clear;
    int            m_pos, m_wait, cyc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic          m_w, m_rdv, m_done;
    owner_e        m_rdown;
    logic          s1_v [8];
    owner_e        s1_o [8];
    logic [DW-1:0] s1_d [8];
    logic          s2_v [8];
    owner_e        s2_o [8];
    logic [DW-1:0] s2_d [8];
    logic          e_gg, e_vg;

    int vec, err;

    task automatic model_reset();
        m_clear = 0;
        m_pos   = 0;
        m_wait  = 0;
        m_addr  = '0;
        m_wd    = '0;
        m_w     = 1'b0;
        m_rdv   = 1'b0;
        m_rdown = OWN_GAME;
        m_done  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s1_v[i] = 1'b0;
            s2_v[i] = 1'b0;
        end
    endtask

    // expected grants for the current cycle, from the stable inputs
    task automatic eval();
        @(negedge clk);
        if (m_clear || clr_req) begin
            e_gg = 1'b0;
            e_vg = 1'b0;
        end else begin
            e_gg = game_req && (!vid_req || m_wait >= MW);
            e_vg = vid_req && !e_gg;
        end
    endtask

    // commit this cycle's memory op, decide the next one, clock once
    task automatic step();
        int i1, i2;
        s1_v[cyc % 8] = 1'b0;
        s2_v[cyc % 8] = 1'b0;
        if (m_w) shadow[m_addr] = m_wd;
        if (m_rdv) begin
            i1 = (cyc + 1) % 8;
            i2 = (cyc + 2) % 8;
            s1_v[i1] = 1'b1; s1_o[i1] = m_rdown; s1_d[i1] = shadow[m_addr];
            s2_v[i2] = 1'b1; s2_o[i2] = m_rdown; s2_d[i2] = shadow[m_addr];
        end
        m_rdv  = 1'b0;
        m_done = 1'b0;
        if (m_clear) begin
            if (m_pos == CELLS - 1) begin
                m_clear = 0;
                m_done  = 1'b1;
                m_w     = 1'b0;
            end else begin
                m_pos++;
                m_addr = AW'(m_pos);
            end
        end else begin
            if (game_req && !e_gg) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else m_wait = 0;
            if (clr_req) begin
                m_clear = 1; m_pos = 0; m_addr = '0; m_w = 1'b1; m_wd = '0;
            end else if (e_gg) begin
                m_addr = game_addr; m_w = game_w_nr; m_wd = game_wdata;
                m_rdv = !game_w_nr; m_rdown = OWN_GAME;
            end else if (e_vg) begin
                m_addr = vid_addr; m_w = 1'b0;
                m_rdv = 1'b1; m_rdown = OWN_VID;
            end else begin
                m_w = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        eval();
        vec++;
        if ({m1_a, m1_wd, m1_w, c1_busy, c1_done} !== '0) begin
            err++;
            $display("FAIL reset_outs: got %h want 0",
                     {m1_a, m1_wd, m1_w, c1_busy, c1_done});
        end
        vec++;
        if ({g1_rv, v1_rv, g2_rv, v2_rv} !== 4'b0) begin
            err++;
            $display("FAIL reset_rvalid: got %b want 0000",
                     {g1_rv, v1_rv, g2_rv, v2_rv});
        end
        step();
    endtask

    task automatic test_game_write();
        game_req = 1; game_w_nr = 1; game_addr = 8'h23; game_wdata = 2'b01;
        vid_req = 0;
        eval();
        vec++;
        if ({g1_gnt, v1_gnt} !== 2'b10) begin
            err++; $display("FAIL wr_gnt: got %b want 10", {g1_gnt, v1_gnt});
        end
        step();
        game_req = 0;
        eval();
        vec++;
        if ({m1_a, m1_wd, m1_w} !== {8'h23, 2'b01, 1'b1}) begin
            err++;
            $display("FAIL wr_mem: got %h/%b/%b want 23/01/1", m1_a, m1_wd, m1_w);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            eval();
            vec++;
            if ({g1_rv, v1_rv, g2_rv, v2_rv} !== 4'b0) begin
                err++;
                $display("FAIL wr_no_rvalid[%0d]: got %b want 0000", k,
                         {g1_rv, v1_rv, g2_rv, v2_rv});
            end
        end
        step();
    endtask

    task automatic test_game_read();
        game_req = 1; game_w_nr = 0; game_addr = 8'h23;
        eval();
        vec++;
        if (g1_gnt !== 1'b1) begin
            err++; $display("FAIL rd_gnt: got %b want 1", g1_gnt);
        end
        step();
        game_req = 0;
        eval();
        vec++;
        if ({m1_a, m1_w} !== {8'h23, 1'b0}) begin
            err++; $display("FAIL rd_mem: got %h/%b want 23/0", m1_a, m1_w);
        end
        step();
        eval();
        vec++;
        if ({g1_rv, g1_rd, v1_rv, g2_rv} !== 5'b10100) begin
            err++;
            $display("FAIL rd_lat1: got rv=%b d=%b vrv=%b rv2=%b want 1 01 0 0",
                     g1_rv, g1_rd, v1_rv, g2_rv);
        end
        step();
        eval();
        vec++;
        if ({g2_rv, g2_rd, g1_rv} !== 4'b1010) begin
            err++;
            $display("FAIL rd_lat2: got rv2=%b d=%b rv1=%b want 1 01 0",
                     g2_rv, g2_rd, g1_rv);
        end
        step();
    endtask

    task automatic test_starvation();
        vid_req = 1; vid_addr = 8'h40;
        game_req = 1; game_w_nr = 0; game_addr = 8'h23;
        for (int i = 0; i < 4; i++) begin
            eval();
            vec++;
            if ({g1_gnt, v1_gnt} !== ((i == 3) ? 2'b10 : 2'b01)) begin
                err++;
                $display("FAIL starve_arb[%0d]: got %b want %b", i,
                         {g1_gnt, v1_gnt}, (i == 3) ? 2'b10 : 2'b01);
            end
            step();
        end
        game_req = 0;
        eval();
        vec++;
        if ({g1_gnt, v1_gnt} !== 2'b01) begin
            err++;
            $display("FAIL starve_after: got %b want 01", {g1_gnt, v1_gnt});
        end
        step();
        vid_req = 0;
        repeat (4) begin eval(); step(); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = shadow[i];
        for (int k = 0; k < 7; k++) begin
            vid_req  = (k < 3);
            vid_addr = (k < 3) ? AW'(k) : '0;
            eval();
            if (k < 3) begin
                vec++;
                if (v1_gnt !== 1'b1) begin
                    err++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, v1_gnt);
                end
            end
            if (k >= 2 && k < 5) begin
                vec++;
                if ({v1_rv, v1_rd} !== {1'b1, d[k-2]}) begin
                    err++;
                    $display("FAIL b2b_lat1[%0d]: got %b/%b want 1/%b",
                             k, v1_rv, v1_rd, d[k-2]);
                end
            end
            if (k >= 3 && k < 6) begin
                vec++;
                if ({v2_rv, v2_rd} !== {1'b1, d[k-3]}) begin
                    err++;
                    $display("FAIL b2b_lat2[%0d]: got %b/%b want 1/%b",
                             k, v2_rv, v2_rd, d[k-3]);
                end
            end
            if (k == 6) begin
                vec++;
                if ({v1_rv, v2_rv} !== 2'b00) begin
                    err++;
                    $display("FAIL b2b_end: got %b want 00", {v1_rv, v2_rv});
                end
            end
            step();
        end
    endtask

    task automatic test_clear();
        game_req = 1; game_w_nr = 0; game_addr = 8'h23;
        vid_req = 0; clr_req = 1;
        eval();
        vec++;
        if ({g1_gnt, v1_gnt, c1_busy} !== 3'b000) begin
            err++;
            $display("FAIL clr_start: got %b want 000", {g1_gnt, v1_gnt, c1_busy});
        end
        step();
        for (int k = 0; k < CELLS; k++) begin
            clr_req = (k == 5);
            eval();
            vec++;
            if ({c1_busy, c1_done, g1_gnt, m1_w, m1_a, m1_wd} !==
                {4'b1001, AW'(k), 2'b00}) begin
                err++;
                $display("FAIL clr_sweep[%0d]: got b%b d%b g%b w%b a%h wd%b", k,
                         c1_busy, c1_done, g1_gnt, m1_w, m1_a, m1_wd);
            end
            step();
        end
        clr_req = 0;
        eval();
        vec++;
        if ({c1_done, c1_busy, g1_gnt} !== 3'b101) begin
            err++;
            $display("FAIL clr_done: got %b want 101", {c1_done, c1_busy, g1_gnt});
        end
        step();
        game_req = 0;
        eval();
        vec++;
        if (c1_done !== 1'b0) begin
            err++; $display("FAIL clr_done_pulse: got %b want 0", c1_done);
        end
        step();
        repeat (3) begin eval(); step(); end
    endtask

    task automatic test_reset_mid_sweep();
        clr_req = 1;
        eval();
        step();
        clr_req = 0;
        for (int k = 0; k < 40; k++) begin eval(); step(); end
        eval();
        vec++;
        if (m1_a !== 8'd40) begin
            err++; $display("FAIL mid_addr: got %h want 28", m1_a);
        end
        #2 rst = 1;
        #1;
        vec++;
        if ({m1_a, m1_wd, m1_w, c1_busy, c1_done, g1_rv, v1_rv} !== '0) begin
            err++;
            $display("FAIL rst_async: got a%h w%b b%b", m1_a, m1_w, c1_busy);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        cyc++;
        for (int k = 0; k < 5; k++) begin
            eval();
            vec++;
            if ({c1_busy, c1_done} !== 2'b00) begin
                err++;
                $display("FAIL rst_no_done[%0d]: got %b want 00", k,
                         {c1_busy, c1_done});
            end
            step();
        end
        clr_req = 1;
        eval();
        step();
        clr_req = 0;
        eval();
        vec++;
        if ({c1_busy, m1_a, m1_w} !== {1'b1, 8'h00, 1'b1}) begin
            err++;
            $display("FAIL restart: got b%b a%h w%b want 1/00/1",
                     c1_busy, m1_a, m1_w);
        end
        for (int k = 0; k < CELLS; k++) begin step(); eval(); end
        vec++;
        if ({c1_done, c1_busy} !== 2'b10) begin
            err++;
            $display("FAIL restart_done: got %b want 10", {c1_done, c1_busy});
        end
        step();
    endtask

    task automatic test_random();
        logic gg, vg, quiet;
        int   ix;
        game_req = 0; vid_req = 0; clr_req = 0;
        for (int n = 0; n < 700; n++) begin
            quiet = (n >= 690);
            eval();
            ix = cyc % 8;
            vec++;
            if ({g1_gnt, v1_gnt, g2_gnt, v2_gnt} !== {e_gg, e_vg, e_gg, e_vg}) begin
                err++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", n,
                         {g1_gnt, v1_gnt, g2_gnt, v2_gnt}, {e_gg, e_vg, e_gg, e_vg});
            end
            vec++;
            if ({m1_a, m1_w, c1_busy, c1_done} !== {m_addr, m_w, m_clear, m_done}) begin
                err++;
                $display("FAIL rnd_mem[%0d]: got a%h w%b b%b d%b want a%h w%b b%b d%b",
                         n, m1_a, m1_w, c1_busy, c1_done, m_addr, m_w, m_clear, m_done);
            end
            if (m_w) begin
                vec++;
                if (m1_wd !== m_wd) begin
                    err++; $display("FAIL rnd_wdata[%0d]: got %b want %b", n, m1_wd, m_wd);
                end
            end
            vec++;
            if ({g1_rv, v1_rv} !== {s1_v[ix] && s1_o[ix] == OWN_GAME,
                                    s1_v[ix] && s1_o[ix] == OWN_VID}) begin
                err++;
                $display("FAIL rnd_rv1[%0d]: got %b", n, {g1_rv, v1_rv});
            end
            if (s1_v[ix]) begin
                vec++;
                if ((s1_o[ix] == OWN_GAME ? g1_rd : v1_rd) !== s1_d[ix]) begin
                    err++;
                    $display("FAIL rnd_rd1[%0d]: got %b want %b", n,
                             s1_o[ix] == OWN_GAME ? g1_rd : v1_rd, s1_d[ix]);
                end
            end
            vec++;
            if ({g2_rv, v2_rv} !== {s2_v[ix] && s2_o[ix] == OWN_GAME,
                                    s2_v[ix] && s2_o[ix] == OWN_VID}) begin
                err++;
                $display("FAIL rnd_rv2[%0d]: got %b", n, {g2_rv, v2_rv});
            end
            if (s2_v[ix]) begin
                vec++;
                if ((s2_o[ix] == OWN_GAME ? g2_rd : v2_rd) !== s2_d[ix]) begin
                    err++;
                    $display("FAIL rnd_rd2[%0d]: got %b want %b", n,
                             s2_o[ix] == OWN_GAME ? g2_rd : v2_rd, s2_d[ix]);
                end
            end
            gg = e_gg;
            vg = e_vg;
            step();
            if (!game_req || gg) begin
                game_req   = !quiet && ($urandom_range(0, 2) != 0);
                game_w_nr  = 1'($urandom_range(0, 1));
                game_addr  = AW'($urandom_range(0, CELLS - 1));
                game_wdata = DW'($urandom);
            end
            if (!vid_req || vg) begin
                vid_req  = !quiet && ($urandom_range(0, 3) != 0);
                vid_addr = AW'($urandom_range(0, CELLS - 1));
            end
            clr_req = !quiet && ($urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        vec = 0; err = 0; cyc = 0;
        rst = 1; seed_en = 1;
        game_req = 0; game_w_nr = 0; game_addr = '0; game_wdata = '0;
        vid_req = 0; vid_addr = '0; clr_req = 0;
        for (int i = 0; i < 256; i++) begin
            seed[i]   = DW'($urandom);
            shadow[i] = seed[i];
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        seed_en = 0;
        rst = 0;
        test_reset();
        test_game_write();
        test_game_read();
        test_starvation();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
